alu_nibble_sequencer: RTL and testbench

// Multi-cycle controller that runs WIDTH-bit ALU operations on the existing
// 4-bit ALU slice, one nibble per clock, LSB nibble first, with slice carry-out

---
 rtl/alu_nibble_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// Runs WIDTH-bit ALU operations through a 4-bit ALU slice, one nibble per clock,
// LSB first, chaining the registered slice carry-out into the next nibble.
module alu_nibble_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  input  logic [3:0]       alu_result,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_overflow,
  output logic             out_zero
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [2:0]  OP_SUB = 3'b110;
  localparam logic [2:0]  OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [WIDTH-1:0] res_next;
  logic             last;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    res_d    = res_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    res_next = res_q;
    last     = (cnt_q == CW'(NIB - 1));
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    alu_cin  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int unsigned i = 0; i < NIB; i++) begin
          if (cnt_q == CW'(i)) begin
            alu_a                = a_q[4*i +: 4];
            alu_b                = b_q[4*i +: 4];
            res_next[4*i +: 4]   = alu_result;
          end
        end
        alu_op  = (op_q == OP_SLT) ? OP_SUB : op_q;
        alu_cin = (cnt_q == '0) ? op_q[2] : carry_q;
        carry_d = alu_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          // SLT: sign of the difference corrected by overflow gives signed a<b
          if (op_q == OP_SLT) begin
            res_next    = '0;
            res_next[0] = alu_result[3] ^ alu_overflow;
          end
          cout_d  = op_q[1] & alu_cout;
          ovf_d   = op_q[1] & alu_overflow;
          zero_d  = (res_next == '0);
          state_d = S_DONE;
        end
        res_d = res_next;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign out_result   = res_q;
  assign out_cout     = cout_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Randomized bench for alu_nibble_sequencer with a behavioural 4-bit slice and a
// whole-word arithmetic reference model.
module tb_alu_nibble_sequencer;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [2:0]    in_op;
  logic [3:0]    alu_a, alu_b, alu_result;
  logic [2:0]    alu_op;
  logic          alu_cin, alu_cout, alu_overflow;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic          out_cout, out_overflow, out_zero;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  alu_nibble_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout),
    .out_overflow(out_overflow), .out_zero(out_zero)
  );

  // Behavioural 4-bit slice
  logic [3:0] s_bb;
  logic [4:0] s_sum;
  always_comb begin
    s_bb         = alu_op[2] ? ~alu_b : alu_b;
    s_sum        = {1'b0, alu_a} + {1'b0, s_bb} + {4'b0, alu_cin};
    alu_result   = alu_a ^ alu_b;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010, 3'b110: begin
        alu_result   = s_sum[3:0];
        alu_cout     = s_sum[4];
        alu_overflow = (alu_a[3] == s_bb[3]) && (s_sum[3] != alu_a[3]);
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                           output logic [W-1:0] res, output logic c, output logic v,
                           output logic z);
    logic [W:0] s;
    s = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: begin
        s   = {1'b0, a} + {1'b0, b};
        res = s[W-1:0];
        c   = s[W];
        v   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      end
      default: begin
        s   = {1'b0, a} + {1'b0, ~b} + 1;
        res = s[W-1:0];
        c   = s[W];
        v   = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        if (op == 3'b111) res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      end
    endcase
    z = (res == '0);
  endtask

  function automatic logic exp_cin(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op, input int k);
    longint unsigned mask, bb, sum;
    if (k == 0) return op[2];
    if (!op[1]) return 1'b0;
    mask = (64'd1 << (4 * k)) - 1;
    bb   = op[2] ? {48'd0, ~b} : {48'd0, b};
    sum  = ({48'd0, a} & mask) + (bb & mask) + {63'd0, op[2]};
    return sum[4 * k];
  endfunction

  task automatic check_reset_state();
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_result", {16'd0, out_result}, 0);
    check("rst_flags", {29'd0, out_cout, out_overflow, out_zero}, 0);
    check("rst_alu_drive", {20'd0, alu_a, alu_b, alu_op, alu_cin}, 0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input int unsigned stall, input int abort_k);
    logic [W-1:0] er;
    logic         ec, ev, ez;
    int unsigned  waitc;
    ref_model(a, b, op, er, ec, ev, ez);
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    @(posedge clk);
    for (int k = 0; k < int'(NIB); k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_op    = 3'($urandom);
      check("alu_a", {28'd0, alu_a}, {28'd0, 4'((a >> (4 * k)) & 16'hF)});
      check("alu_b", {28'd0, alu_b}, {28'd0, 4'((b >> (4 * k)) & 16'hF)});
      check("alu_op", {29'd0, alu_op}, (op == 3'b111) ? 32'd6 : {29'd0, op});
      check("alu_cin", {31'd0, alu_cin}, {31'd0, exp_cin(a, b, op, k)});
      check("busy", {30'd0, in_ready, out_valid}, 0);
      if (k == abort_k) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        return;
      end
    end
    @(negedge clk);
    check("out_valid_latency", {31'd0, out_valid}, 1);
    check("out_result", {16'd0, out_result}, {16'd0, er});
    check("out_flags", {29'd0, out_cout, out_overflow, out_zero}, {29'd0, ec, ev, ez});
    check("idle_alu_drive", {20'd0, alu_a, alu_b, alu_op, alu_cin}, 0);
    for (int unsigned d = 0; d < stall; d++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a     = W'($urandom);
      @(negedge clk);
      check("stall_hold", {13'd0, in_ready, out_valid, out_result, out_cout, out_overflow, out_zero},
            {13'd0, 1'b0, 1'b1, er, ec, ev, ez});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release", {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state();

    run_op(16'h00FF, 16'h0001, 3'b010, 0, -1);
    run_op(16'h8000, 16'h0001, 3'b110, 1, -1);
    run_op(16'hFFFF, 16'h0001, 3'b111, 0, -1);
    run_op(16'h0001, 16'hFFFF, 3'b111, 2, -1);
    run_op(16'hF0F0, 16'h0F0F, 3'b000, 5, -1);
    run_op(16'h1234, 16'h5678, 3'b010, 0, 2);
    run_op(16'h0001, 16'h0001, 3'b010, 0, -1);

    for (int n = 0; n < 60; n++)
      run_op(W'($urandom), W'($urandom), ops[$urandom_range(0, 4)], $urandom_range(0, 3), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
